// File: rtl/instr_sequencer_if.sv
// Fetch/execute handshake bundle between instr_sequencer and memory/execute stage.
// IrqReq/IrqAck exist only when SEQ_IRQ_EN is defined.
interface instr_sequencer_if;
  logic        MemRdy;
  logic [15:0] MemData;
  logic        ExecDone;
  logic        MemRdReq;
  logic        PCinc;
  logic [15:0] IR;
  logic [15:0] SrcExt;
  logic [15:0] DstExt;
  logic        ExecStart;
  logic        Busy;
  logic        Fault;
  logic [2:0]  State;
`ifdef SEQ_IRQ_EN
  logic        IrqReq;
  logic        IrqAck;
`endif

  modport master (
    input  MemRdy, MemData, ExecDone,
`ifdef SEQ_IRQ_EN
    input  IrqReq,
    output IrqAck,
`endif
    output MemRdReq, PCinc, IR, SrcExt, DstExt, ExecStart, Busy, Fault, State
  );

  modport slave (
    output MemRdy, MemData, ExecDone,
`ifdef SEQ_IRQ_EN
    output IrqReq,
    input  IrqAck,
`endif
    input  MemRdReq, PCinc, IR, SrcExt, DstExt, ExecStart, Busy, Fault, State
  );
endinterface

// File: rtl/instr_sequencer.sv
// MSP430 front-end: fetches instruction + extension words, launches execute, waits for done.
// Optional interrupt entry state compiled in with SEQ_IRQ_EN.
//
// state | meaning
// FETCH | read instruction word into IR
// SRCX  | read source extension word
// DSTX  | read destination extension word
// EXEC  | one-cycle execute-start pulse
// WAITX | hold registers until ExecDone
// HALT  | bus timeout, sticky until reset
// IRQ   | one-cycle interrupt acknowledge (SEQ_IRQ_EN only)
module instr_sequencer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic               clk,
  input  logic               rst,
  instr_sequencer_if.master  bus
);

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_SRCX  = 3'd1;
  localparam logic [2:0] S_DSTX  = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_WAITX = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;
`ifdef SEQ_IRQ_EN
  localparam logic [2:0] S_IRQ   = 3'd6;
`endif
  localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

  logic [2:0]  state, state_nxt;
  logic [15:0] ir_q, src_q, dst_q;
  logic        dst_pend;
  logic        fault_q;
  logic [7:0]  wcnt;
  logic        mem_req, word_ok, waiting, timeout;
  logic        dec_src, dec_dst;

  function automatic logic ext_mode(input logic [1:0] as_mode, input logic [3:0] rg);
    return (as_mode == 2'b01 && rg != 4'd3) || (as_mode == 2'b11 && rg == 4'd0);
  endfunction

  always_comb begin
    dec_src = 1'b0;
    dec_dst = 1'b0;
    if (bus.MemData[15:12] >= 4'd4) begin
      dec_src = ext_mode(bus.MemData[5:4], bus.MemData[11:8]);
      dec_dst = bus.MemData[7];
    end else if (bus.MemData[15:12] == 4'd1 && bus.MemData != 16'h1300) begin
      dec_src = ext_mode(bus.MemData[5:4], bus.MemData[3:0]);
    end
  end

  // Strobes are masked during reset so a pending MemRdy has no visible effect.
  assign mem_req = !rst && (state == S_FETCH || state == S_SRCX || state == S_DSTX);
  assign word_ok = mem_req && bus.MemRdy;
  assign waiting = mem_req && !bus.MemRdy;
  assign timeout = waiting && (wcnt == WAIT_LIM - 8'd1);

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: if (word_ok) state_nxt = dec_src ? S_SRCX : (dec_dst ? S_DSTX : S_EXEC);
      S_SRCX:  if (word_ok) state_nxt = dst_pend ? S_DSTX : S_EXEC;
      S_DSTX:  if (word_ok) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_WAITX;
`ifdef SEQ_IRQ_EN
      S_WAITX: if (bus.ExecDone) state_nxt = bus.IrqReq ? S_IRQ : S_FETCH;
      S_IRQ:   state_nxt = S_FETCH;
`else
      S_WAITX: if (bus.ExecDone) state_nxt = S_FETCH;
`endif
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase
    if (timeout) state_nxt = S_HALT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      ir_q     <= 16'h4303;
      src_q    <= 16'h0000;
      dst_q    <= 16'h0000;
      dst_pend <= 1'b0;
      fault_q  <= 1'b0;
      wcnt     <= 8'd0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || word_ok) wcnt <= 8'd0;
      else if (waiting)                  wcnt <= wcnt + 8'd1;
      if (timeout) fault_q <= 1'b1;
      if (word_ok) begin
        case (state)
          S_FETCH: begin
            ir_q     <= bus.MemData;
            dst_pend <= dec_dst;
          end
          S_SRCX:  src_q <= bus.MemData;
          S_DSTX:  dst_q <= bus.MemData;
          default: ;
        endcase
      end
    end
  end

  assign bus.MemRdReq  = mem_req;
  assign bus.PCinc     = word_ok;
  assign bus.ExecStart = !rst && state == S_EXEC;
  assign bus.Busy      = !rst && !(state == S_FETCH && !bus.MemRdy);
  assign bus.Fault     = fault_q;
  assign bus.State     = state;
  assign bus.IR        = ir_q;
  assign bus.SrcExt    = src_q;
  assign bus.DstExt    = dst_q;
`ifdef SEQ_IRQ_EN
  assign bus.IrqAck    = !rst && state == S_IRQ;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: random instruction streams, timeout, reset and IRQ cases.
module tb_instr_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_sequencer_if bus_if();
  instr_sequencer #(.MAX_WAIT(15)) dut (.clk(clk), .rst(rst), .bus(bus_if));

  typedef struct {
    logic [15:0] ir;
    logic [15:0] src;
    logic [15:0] dst;
    int          nwords;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  exp_t        exp_q[$];
  logic [15:0] stream_q[$];
  logic [15:0] last_src = 16'h0;
  logic [15:0] last_dst = 16'h0;
  bit          mon_en = 1'b0;
  bit          rdy_always = 1'b0;
  int          ret_cycle = -10;
  int          done_cnt = 0;
  int          pc_cnt = 0;
  int          last_pc = -10;
  exp_t        mon_e;
  logic [15:0] rw;
  int          budget;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference rule: which extension words an instruction word pulls in.
  function automatic void need_ext(input logic [15:0] w, output bit s, output bit d);
    int op, as_mode, rg;
    op = int'(w[15:12]);
    as_mode = int'(w[5:4]);
    s = 1'b0;
    d = 1'b0;
    rg = -1;
    if (op >= 4) begin
      rg = int'(w[11:8]);
      d = w[7];
    end else if (op == 1 && w != 16'h1300) begin
      rg = int'(w[3:0]);
    end
    if (rg >= 0) s = (as_mode == 1 && rg != 3) || (as_mode == 3 && rg == 0);
  endfunction

  task automatic issue(input logic [15:0] w, input logic [15:0] x1, input logic [15:0] x2);
    bit s, d;
    exp_t e;
    need_ext(w, s, d);
    stream_q.push_back(w);
    e.ir = w;
    e.src = last_src;
    e.dst = last_dst;
    if (s) begin stream_q.push_back(x1); e.src = x1; last_src = x1; end
    if (d) begin stream_q.push_back(x2); e.dst = x2; last_dst = x2; end
    e.nwords = 1 + int'(s) + int'(d);
    exp_q.push_back(e);
  endtask

  // One cycle of memory + execute-stage responder.
  task automatic step();
    @(posedge clk); #1;
    if (bus_if.ExecStart) begin
      bus_if.ExecDone = 1'($urandom_range(0, 1));
      done_cnt = $urandom_range(1, 4);
    end else if (done_cnt > 0) begin
      done_cnt--;
      bus_if.ExecDone = (done_cnt == 0);
      if (done_cnt == 0) ret_cycle = cyc + 1;
    end else begin
      bus_if.ExecDone = 1'b0;
    end
    if (stream_q.size() > 0) begin
      bus_if.MemData = stream_q[0];
      bus_if.MemRdy = rdy_always || ($urandom_range(0, 3) != 0);
    end else begin
      bus_if.MemRdy = 1'b0;
    end
    @(negedge clk);
    if (bus_if.PCinc && stream_q.size() > 0) void'(stream_q.pop_front());
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_state"}, 32'(bus_if.State), 32'd0);
    chk({tag, "_ir"}, 32'(bus_if.IR), 32'h4303);
    chk({tag, "_srcext"}, 32'(bus_if.SrcExt), 32'h0);
    chk({tag, "_dstext"}, 32'(bus_if.DstExt), 32'h0);
    chk({tag, "_memrdreq"}, 32'(bus_if.MemRdReq), 32'h0);
    chk({tag, "_pcinc"}, 32'(bus_if.PCinc), 32'h0);
    chk({tag, "_execstart"}, 32'(bus_if.ExecStart), 32'h0);
    chk({tag, "_fault"}, 32'(bus_if.Fault), 32'h0);
    chk({tag, "_busy"}, 32'(bus_if.Busy), 32'h0);
`ifdef SEQ_IRQ_EN
    chk({tag, "_irqack"}, 32'(bus_if.IrqAck), 32'h0);
`endif
  endtask

  // Reset with a pending MemRdy that must be ignored.
  task automatic do_reset(input string tag);
    bus_if.MemRdy = 1'b1;
    bus_if.MemData = 16'hBEEF;
    bus_if.ExecDone = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    reset_checks(tag);
    rst = 1'b0;
    bus_if.MemRdy = 1'b0;
    last_src = 16'h0;
    last_dst = 16'h0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus_if.PCinc) begin
        pc_cnt++;
        last_pc = cyc;
      end
      if (bus_if.ExecStart) begin
        if (exp_q.size() == 0) begin
          chk("exec_unexpected", 32'(bus_if.ExecStart), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("ir", 32'(bus_if.IR), 32'(mon_e.ir));
          chk("srcext", 32'(bus_if.SrcExt), 32'(mon_e.src));
          chk("dstext", 32'(bus_if.DstExt), 32'(mon_e.dst));
          chk("pcinc_count", pc_cnt, mon_e.nwords);
          chk("exec_latency", cyc - last_pc, 1);
          pc_cnt = 0;
        end
      end
      if (cyc == ret_cycle) chk("return_fetch", 32'(bus_if.State), 32'd0);
    end
  end

  initial begin
    bus_if.MemRdy = 1'b0;
    bus_if.MemData = 16'h0;
    bus_if.ExecDone = 1'b0;
`ifdef SEQ_IRQ_EN
    bus_if.IrqReq = 1'b0;
`endif
    do_reset("init");

    // Directed instruction forms with zero-wait memory.
    mon_en = 1'b1;
    rdy_always = 1'b1;
    issue(16'h4F0F, 16'h1111, 16'h2222);
    issue(16'h403F, 16'h1234, 16'h2222);
    issue(16'h4092, 16'h0010, 16'h0200);
    issue(16'h3C05, 16'h3333, 16'h4444);
    issue(16'h4313, 16'h5555, 16'h6666);
    budget = 0;
    while (exp_q.size() > 0 && budget < 400) begin step(); budget++; end
    chk("directed_drain", exp_q.size(), 0);

    // Random instruction stream with random wait states.
    rdy_always = 1'b0;
    for (int i = 0; i < 40; i++) begin
      rw = 16'($urandom);
      case ($urandom_range(0, 7))
        0: rw = 16'h1300;
        1, 2: begin
          if (rw[15:12] >= 4'd4) rw[11:8] = ($urandom_range(0, 1) != 0) ? 4'd3 : 4'd0;
          else rw[3:0] = ($urandom_range(0, 1) != 0) ? 4'd3 : 4'd0;
        end
        default: ;
      endcase
      issue(rw, 16'($urandom), 16'($urandom));
    end
    budget = 0;
    while (exp_q.size() > 0 && budget < 5000) begin step(); budget++; end
    chk("random_drain", exp_q.size(), 0);
    repeat (6) step();
    mon_en = 1'b0;

    // Reset taken while in SRCX.
    do_reset("rst2");
    bus_if.MemRdy = 1'b1;
    bus_if.MemData = 16'h403F;
    @(posedge clk); #1;
    bus_if.MemRdy = 1'b0;
    chk("midop_srcx_state", 32'(bus_if.State), 32'd1);
    chk("midop_srcx_ir", 32'(bus_if.IR), 32'h403F);
    do_reset("midop");

    // Bus timeout into HALT.
    repeat (14) @(posedge clk);
    #1;
    chk("pre_timeout_state", 32'(bus_if.State), 32'd0);
    chk("pre_timeout_fault", 32'(bus_if.Fault), 32'd0);
    chk("idle_busy", 32'(bus_if.Busy), 32'd0);
    @(posedge clk); #1;
    chk("timeout_state", 32'(bus_if.State), 32'd5);
    chk("timeout_fault", 32'(bus_if.Fault), 32'd1);
    chk("timeout_memrdreq", 32'(bus_if.MemRdReq), 32'd0);
    bus_if.MemRdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("halt_state", 32'(bus_if.State), 32'd5);
      chk("halt_pcinc", 32'(bus_if.PCinc), 32'd0);
      chk("halt_fault", 32'(bus_if.Fault), 32'd1);
    end
    do_reset("fault_clr");

`ifdef SEQ_IRQ_EN
    bus_if.IrqReq = 1'b1;
    bus_if.MemRdy = 1'b1;
    bus_if.MemData = 16'h4F0F;
    @(posedge clk); #1;
    bus_if.MemRdy = 1'b0;
    bus_if.ExecDone = 1'b1;
    chk("irq_exec_state", 32'(bus_if.State), 32'd3);
    chk("irq_execstart", 32'(bus_if.ExecStart), 32'd1);
    @(posedge clk); #1;
    chk("irq_waitx_state", 32'(bus_if.State), 32'd4);
    chk("irq_waitx_ack", 32'(bus_if.IrqAck), 32'd0);
    @(posedge clk); #1;
    bus_if.ExecDone = 1'b0;
    bus_if.IrqReq = 1'b0;
    chk("irq_state", 32'(bus_if.State), 32'd6);
    chk("irq_ack", 32'(bus_if.IrqAck), 32'd1);
    chk("irq_ir_kept", 32'(bus_if.IR), 32'h4F0F);
    @(posedge clk); #1;
    chk("irq_back_fetch", 32'(bus_if.State), 32'd0);
    chk("irq_ack_clear", 32'(bus_if.IrqAck), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
